usbt_parse_fifo_drain_ctrl: RTL and testbench

Read-side sequencer for the main-parse FIFO: decides when to drain the FIFO and pops entries one at a time into a registered valid/ready stream toward the CPU/DMA path. Draining starts only in one of three cases: a complete packet is buffered, the fill level reaches a cut-through threshold, or a stalled partial packet times out. Each drain runs packet-by-packet, with SOP/EOP framing recovered from the FIFO entries.

---
 rtl/usbt_parse_fifo_drain_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_usbt_parse_fifo_drain_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/usbt_parse_fifo_drain_ctrl.sv
// Read-side drain sequencer for the main-parse FIFO: starts packet drains and streams entries out.
// Optional partial-packet timeout trigger is built when USBT_DRAIN_TIMEOUT_EN is defined.
module usbt_parse_fifo_drain_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int COD_ENDP_WIDTH = 6,
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int PKT_CNT_WIDTH  = 8,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [RAM_ADDR_WIDTH:0]   cut_through_th,
  input  logic [TIMEOUT_WIDTH-1:0]  timeout_value,
  input  logic                      wr_eop,
  input  logic                      fifo_read_ready,
  input  logic [RAM_ADDR_WIDTH:0]   fifo_read_used,
  input  logic                      fifo_eop,
  input  logic                      fifo_error,
  input  logic                      fifo_entry_type,
  input  logic [1:0]                fifo_d_width,
  input  logic [COD_ENDP_WIDTH-1:0] fifo_endp_entry,
  input  logic [DATA_WIDTH-1:0]     fifo_data,
  output logic                      fifo_read_command,
  input  logic                      dn_ready,
  output logic                      dn_valid,
  output logic                      dn_sop,
  output logic                      dn_eop,
  output logic                      dn_error,
  output logic                      dn_entry_type,
  output logic [1:0]                dn_d_width,
  output logic [COD_ENDP_WIDTH-1:0] dn_endp,
  output logic [DATA_WIDTH-1:0]     dn_data,
  output logic [PKT_CNT_WIDTH-1:0]  pkt_pending,
  output logic [PKT_CNT_WIDTH-1:0]  drained_pkt_cnt,
  output logic                      timeout_flag,
  output logic                      cnt_err,
  input  logic                      err_clr
);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_e;

  localparam logic [PKT_CNT_WIDTH-1:0]  PKT_ZERO = {PKT_CNT_WIDTH{1'b0}};
  localparam logic [PKT_CNT_WIDTH-1:0]  PKT_ONES = {PKT_CNT_WIDTH{1'b1}};
  localparam logic [PKT_CNT_WIDTH-1:0]  PKT_ONE  = {{(PKT_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RAM_ADDR_WIDTH:0]   TH_ZERO  = {(RAM_ADDR_WIDTH+1){1'b0}};

  state_e                      state_q, state_d;
  logic                        sop_pend_q, sop_pend_d;
  logic                        dn_valid_q, dn_valid_d;
  logic                        dn_sop_q, dn_sop_d;
  logic                        dn_eop_q, dn_eop_d;
  logic                        dn_error_q, dn_error_d;
  logic                        dn_entry_type_q, dn_entry_type_d;
  logic [1:0]                  dn_d_width_q, dn_d_width_d;
  logic [COD_ENDP_WIDTH-1:0]   dn_endp_q, dn_endp_d;
  logic [DATA_WIDTH-1:0]       dn_data_q, dn_data_d;
  logic [PKT_CNT_WIDTH-1:0]    pkt_pending_q, pkt_pending_d;
  logic [PKT_CNT_WIDTH-1:0]    drained_q, drained_d;
  logic                        timeout_flag_q, timeout_flag_d;
  logic                        cnt_err_q, cnt_err_d;

  logic pop_s;
  logic eop_pop_s;
  logic th_trig_s;
  logic to_hit_s;
  logic go_s;

`ifdef USBT_DRAIN_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] TO_ZERO = {TIMEOUT_WIDTH{1'b0}};
  localparam logic [TIMEOUT_WIDTH-1:0] TO_ONES = {TIMEOUT_WIDTH{1'b1}};
  logic [TIMEOUT_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic                     to_run_s;

  // Idle-with-data cycle counter; hit fires on the timeout_value-th such cycle.
  always_comb begin
    to_run_s = (state_q == IDLE) && fifo_read_ready && (pkt_pending_q == PKT_ZERO);
    to_hit_s = 1'b0;
    to_cnt_d = TO_ZERO;
    if (to_run_s) begin
      to_hit_s = (timeout_value != TO_ZERO) &&
                 (({1'b0, to_cnt_q} + {{TIMEOUT_WIDTH{1'b0}}, 1'b1}) >= {1'b0, timeout_value});
      to_cnt_d = (to_cnt_q == TO_ONES) ? to_cnt_q : (to_cnt_q + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1});
    end else begin
      to_hit_s = 1'b0;
      to_cnt_d = TO_ZERO;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_cnt_q <= TO_ZERO;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_flag = timeout_flag_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^timeout_value;
  assign to_hit_s         = 1'b0;
  assign timeout_flag     = 1'b0;
`endif

  // Pop qualification and drain-start decision; gated so nothing pops while in reset.
  always_comb begin
    pop_s     = reset_n && fifo_read_ready && (state_q == STREAM) && (!dn_valid_q || dn_ready);
    eop_pop_s = pop_s && fifo_eop;
    th_trig_s = (cut_through_th != TH_ZERO) && (fifo_read_used >= cut_through_th);
    go_s      = (state_q == IDLE) && enable && fifo_read_ready &&
                ((pkt_pending_q != PKT_ZERO) || th_trig_s || to_hit_s);
  end

  assign fifo_read_command = pop_s;

  // Next-state logic for FSM, output beat, counters and sticky flags.
  always_comb begin
    state_d         = state_q;
    sop_pend_d      = sop_pend_q;
    dn_valid_d      = dn_valid_q;
    dn_sop_d        = dn_sop_q;
    dn_eop_d        = dn_eop_q;
    dn_error_d      = dn_error_q;
    dn_entry_type_d = dn_entry_type_q;
    dn_d_width_d    = dn_d_width_q;
    dn_endp_d       = dn_endp_q;
    dn_data_d       = dn_data_q;
    pkt_pending_d   = pkt_pending_q;
    drained_d       = drained_q;
    timeout_flag_d  = timeout_flag_q;
    cnt_err_d       = cnt_err_q;

    case (state_q)
      IDLE: begin
        if (go_s) begin
          state_d    = STREAM;
          sop_pend_d = 1'b1;
        end else begin
          state_d    = IDLE;
        end
      end
      STREAM: begin
        if (eop_pop_s) begin
          state_d = IDLE;
        end else begin
          state_d = STREAM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop_s) begin
      dn_valid_d      = 1'b1;
      dn_sop_d        = sop_pend_q;
      dn_eop_d        = fifo_eop;
      dn_error_d      = fifo_error;
      dn_entry_type_d = fifo_entry_type;
      dn_d_width_d    = fifo_d_width;
      dn_endp_d       = fifo_endp_entry;
      dn_data_d       = fifo_data;
      sop_pend_d      = 1'b0;
    end else if (dn_ready) begin
      dn_valid_d = 1'b0;
    end else begin
      dn_valid_d = dn_valid_q;
    end

    // A simultaneous commit and drain of an EOP cancel out.
    if (wr_eop && !eop_pop_s) begin
      if (pkt_pending_q == PKT_ONES) begin
        cnt_err_d = 1'b1;
      end else begin
        pkt_pending_d = pkt_pending_q + PKT_ONE;
      end
    end else if (eop_pop_s && !wr_eop) begin
      if (pkt_pending_q == PKT_ZERO) begin
        cnt_err_d = 1'b1;
      end else begin
        pkt_pending_d = pkt_pending_q - PKT_ONE;
      end
    end else begin
      pkt_pending_d = pkt_pending_q;
    end

    if (eop_pop_s) begin
      drained_d = drained_q + PKT_ONE;
    end else begin
      drained_d = drained_q;
    end

    if (go_s && to_hit_s) begin
      timeout_flag_d = 1'b1;
    end else begin
      timeout_flag_d = timeout_flag_q;
    end

    if (err_clr) begin
      timeout_flag_d = 1'b0;
      cnt_err_d      = 1'b0;
    end else begin
      cnt_err_d      = cnt_err_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      sop_pend_q      <= 1'b0;
      dn_valid_q      <= 1'b0;
      dn_sop_q        <= 1'b0;
      dn_eop_q        <= 1'b0;
      dn_error_q      <= 1'b0;
      dn_entry_type_q <= 1'b0;
      dn_d_width_q    <= 2'b00;
      dn_endp_q       <= {COD_ENDP_WIDTH{1'b0}};
      dn_data_q       <= {DATA_WIDTH{1'b0}};
      pkt_pending_q   <= PKT_ZERO;
      drained_q       <= PKT_ZERO;
      timeout_flag_q  <= 1'b0;
      cnt_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      sop_pend_q      <= sop_pend_d;
      dn_valid_q      <= dn_valid_d;
      dn_sop_q        <= dn_sop_d;
      dn_eop_q        <= dn_eop_d;
      dn_error_q      <= dn_error_d;
      dn_entry_type_q <= dn_entry_type_d;
      dn_d_width_q    <= dn_d_width_d;
      dn_endp_q       <= dn_endp_d;
      dn_data_q       <= dn_data_d;
      pkt_pending_q   <= pkt_pending_d;
      drained_q       <= drained_d;
      timeout_flag_q  <= timeout_flag_d;
      cnt_err_q       <= cnt_err_d;
    end
  end

  assign dn_valid        = dn_valid_q;
  assign dn_sop          = dn_sop_q;
  assign dn_eop          = dn_eop_q;
  assign dn_error        = dn_error_q;
  assign dn_entry_type   = dn_entry_type_q;
  assign dn_d_width      = dn_d_width_q;
  assign dn_endp         = dn_endp_q;
  assign dn_data         = dn_data_q;
  assign pkt_pending     = pkt_pending_q;
  assign drained_pkt_cnt = drained_q;
  assign cnt_err         = cnt_err_q;

endmodule

// File: tb/tb_usbt_parse_fifo_drain_ctrl.sv
// Directed bench for usbt_parse_fifo_drain_ctrl with a queue-based show-ahead FIFO model.
module tb_usbt_parse_fifo_drain_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, enable, wr_eop, fifo_read_ready, fifo_eop, fifo_error, fifo_entry_type;
  logic [8:0]  cut_through_th, fifo_read_used;
  logic [15:0] timeout_value;
  logic [1:0]  fifo_d_width, dn_d_width;
  logic [5:0]  fifo_endp_entry, dn_endp;
  logic [31:0] fifo_data, dn_data;
  logic        fifo_read_command, dn_ready, dn_valid, dn_sop, dn_eop, dn_error, dn_entry_type;
  logic [7:0]  pkt_pending, drained_pkt_cnt;
  logic        timeout_flag, cnt_err, err_clr;

  always #5 clk = ~clk;

  usbt_parse_fifo_drain_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cut_through_th(cut_through_th),
    .timeout_value(timeout_value), .wr_eop(wr_eop), .fifo_read_ready(fifo_read_ready),
    .fifo_read_used(fifo_read_used), .fifo_eop(fifo_eop), .fifo_error(fifo_error),
    .fifo_entry_type(fifo_entry_type), .fifo_d_width(fifo_d_width),
    .fifo_endp_entry(fifo_endp_entry), .fifo_data(fifo_data),
    .fifo_read_command(fifo_read_command), .dn_ready(dn_ready), .dn_valid(dn_valid),
    .dn_sop(dn_sop), .dn_eop(dn_eop), .dn_error(dn_error), .dn_entry_type(dn_entry_type),
    .dn_d_width(dn_d_width), .dn_endp(dn_endp), .dn_data(dn_data), .pkt_pending(pkt_pending),
    .drained_pkt_cnt(drained_pkt_cnt), .timeout_flag(timeout_flag), .cnt_err(cnt_err),
    .err_clr(err_clr)
  );

  logic [31:0] q_data[$];
  bit          q_eop[$];
  logic [31:0] rx_data[$];
  bit          rx_sop[$];
  bit          rx_eop[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          pops  = 0;
  bit          stall_seen = 1'b0;
  logic [31:0] stall_data;
  int          p0, r0, n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Side fields are derived from data so field copying is observable.
  task automatic drive_fifo();
    fifo_read_ready = (q_data.size() != 0);
    fifo_read_used  = 9'(q_data.size());
    if (q_data.size() != 0) begin
      fifo_data       = q_data[0];
      fifo_eop        = q_eop[0];
      fifo_error      = 1'b0;
      fifo_d_width    = q_data[0][1:0];
      fifo_endp_entry = q_data[0][7:2];
      fifo_entry_type = q_data[0][8];
    end else begin
      fifo_data = 32'h0; fifo_eop = 1'b0; fifo_error = 1'b0;
      fifo_d_width = 2'b00; fifo_endp_entry = 6'h00; fifo_entry_type = 1'b0;
    end
  endtask

  task automatic push(input logic [31:0] d, input bit e, input bit w);
    q_data.push_back(d);
    q_eop.push_back(e);
    if (w) wr_eop = 1'b1;
    drive_fifo();
  endtask

  task automatic cyc();
    bit cmd;
    @(negedge clk);
    if (stall_seen && dn_valid) chk("stall_hold", dn_data, stall_data);
    stall_seen = dn_valid && !dn_ready;
    stall_data = dn_data;
    if (dn_valid && dn_ready) begin
      rx_data.push_back(dn_data); rx_sop.push_back(dn_sop); rx_eop.push_back(dn_eop);
    end
    cmd = fifo_read_command;
    @(posedge clk);
    #1;
    if (cmd) begin
      q_data.delete(0); q_eop.delete(0); pops++;
    end
    wr_eop = 1'b0;
    drive_fifo();
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; wr_eop = 1'b0; dn_ready = 1'b0; err_clr = 1'b0;
    cut_through_th = 9'd0; timeout_value = 16'd0;
    drive_fifo();
    cyc(); cyc();
    chk("rst_dn_valid", dn_valid, 1'b0);
    chk("rst_pkt_pending", pkt_pending, 8'd0);
    chk("rst_drained", drained_pkt_cnt, 8'd0);
    chk("rst_flags", {timeout_flag, cnt_err}, 2'b00);
    reset_n = 1'b1; enable = 1'b1; dn_ready = 1'b1;

    // Complete 3-entry packet
    push(32'hA1A1_0001, 1'b0, 1'b0);
    push(32'hA2A2_0002, 1'b0, 1'b0);
    push(32'hA3A3_0003, 1'b1, 1'b1);
    cyc();
    chk("t1_pending_up", pkt_pending, 8'd1);
    repeat (9) cyc();
    chk("t1_pending_down", pkt_pending, 8'd0);
    chk("t1_pops", pops, 3);
    chk("t1_beats", rx_data.size(), 3);
    chk("t1_b0", {rx_sop[0], rx_eop[0], rx_data[0]}, {2'b10, 32'hA1A1_0001});
    chk("t1_b1", {rx_sop[1], rx_eop[1], rx_data[1]}, {2'b00, 32'hA2A2_0002});
    chk("t1_b2", {rx_sop[2], rx_eop[2], rx_data[2]}, {2'b01, 32'hA3A3_0003});
    chk("t1_drained", drained_pkt_cnt, 8'd1);

    // Cut-through threshold of 4
    cut_through_th = 9'd4;
    push(32'h2000_0001, 1'b0, 1'b0);
    push(32'h2000_0002, 1'b0, 1'b0);
    push(32'h2000_0003, 1'b0, 1'b0);
    repeat (4) cyc();
    chk("t2_no_pop_below_th", pops, 3);
    push(32'h2000_0004, 1'b0, 1'b0);
    cyc();
    push(32'h2000_0005, 1'b0, 1'b0);
    repeat (8) cyc();
    chk("t2_pops", pops, 8);
    chk("t2_beats", rx_data.size(), 8);
    chk("t2_first", {rx_sop[3], rx_data[3]}, {1'b1, 32'h2000_0001});
    chk("t2_fifth", {rx_sop[7], rx_eop[7], rx_data[7]}, {2'b00, 32'h2000_0005});
    cut_through_th = 9'd0;
    push(32'h2000_0006, 1'b1, 1'b1);
    repeat (5) cyc();
    chk("t2_eop_beat", {rx_sop[8], rx_eop[8], rx_data[8]}, {2'b01, 32'h2000_0006});
    chk("t2_drained", drained_pkt_cnt, 8'd2);
    chk("t2_pending_same_cycle", pkt_pending, 8'd0);
    chk("t2_cnt_err", cnt_err, 1'b0);

    // Partial-packet timeout
    timeout_value = 16'd10;
    p0 = pops;
    push(32'h3000_0001, 1'b0, 1'b0);
`ifdef USBT_DRAIN_TIMEOUT_EN
    n = 0;
    while (pops == p0 && n < 40) begin cyc(); n++; end
    chk("t3_latency", n, 11);
    chk("t3_flag_set", timeout_flag, 1'b1);
`else
    repeat (30) cyc();
    chk("t3_no_drain", pops, p0);
    chk("t3_flag_tied", timeout_flag, 1'b0);
`endif
    timeout_value = 16'd0;
    push(32'h3000_0002, 1'b1, 1'b1);
    repeat (6) cyc();
    chk("t3_drained", drained_pkt_cnt, 8'd3);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t3_flag_clr", timeout_flag, 1'b0);

    // dn_ready toggling over an 8-beat packet
    p0 = pops; r0 = rx_data.size();
    for (int i = 0; i < 8; i++) push(32'h4000_0000 + 32'(i), (i == 7), (i == 7));
    for (int i = 0; i < 40; i++) begin
      dn_ready = (i % 2 == 0);
      cyc();
    end
    dn_ready = 1'b1;
    repeat (3) cyc();
    chk("t4_pops", pops - p0, 8);
    chk("t4_beats", rx_data.size() - r0, 8);
    for (int i = 0; i < 8; i++) chk("t4_data", rx_data[r0 + i], 32'h4000_0000 + 32'(i));
    chk("t4_sop_eop", {rx_sop[r0], rx_eop[r0 + 7]}, 2'b11);
    chk("t4_drained", drained_pkt_cnt, 8'd4);

    // Simultaneous commit and drain, then underflow attempt
    enable = 1'b0;
    push(32'h5000_0001, 1'b1, 1'b1);
    cyc();
    push(32'h5000_0002, 1'b1, 1'b1);
    cyc();
    chk("t5_pending2", pkt_pending, 8'd2);
    enable = 1'b1;
    cyc();
    push(32'h5000_0003, 1'b1, 1'b1);
    cyc();
    chk("t5_pending_hold", pkt_pending, 8'd2);
    repeat (12) cyc();
    chk("t5_pending_zero", pkt_pending, 8'd0);
    chk("t5_drained", drained_pkt_cnt, 8'd7);
    chk("t5_last", {rx_sop[rx_sop.size()-1], rx_eop[rx_eop.size()-1], rx_data[rx_data.size()-1]},
        {2'b11, 32'h5000_0003});
    push(32'h5000_0004, 1'b1, 1'b0);
    cut_through_th = 9'd1;
    repeat (6) cyc();
    chk("t5_underflow_sat", pkt_pending, 8'd0);
    chk("t5_cnt_err", cnt_err, 1'b1);
    chk("t5_drained2", drained_pkt_cnt, 8'd8);
    cut_through_th = 9'd0;
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t5_cnt_err_clr", cnt_err, 1'b0);

    // Reset mid-packet with a stalled beat held
    dn_ready = 1'b0;
    push(32'h6000_00FD, 1'b0, 1'b0);
    push(32'h6000_0002, 1'b0, 1'b0);
    push(32'h6000_0003, 1'b1, 1'b1);
    repeat (4) cyc();
    chk("t6_stalled_beat", {dn_valid, dn_sop, dn_data}, {2'b11, 32'h6000_00FD});
    chk("t6_fields", {dn_d_width, dn_endp}, {2'b01, 6'h3F});
    enable = 1'b0; reset_n = 1'b0; dn_ready = 1'b1;
    #1;
    chk("t6_cmd_in_reset", fifo_read_command, 1'b0);
    p0 = pops;
    cyc();
    chk("t6_rst_beat", {dn_valid, dn_sop, dn_eop, dn_data}, 35'd0);
    chk("t6_rst_cnts", {pkt_pending, drained_pkt_cnt}, 16'd0);
    chk("t6_rst_flags", {timeout_flag, cnt_err}, 2'b00);
    reset_n = 1'b1;
    repeat (10) cyc();
    chk("t6_no_pop_disabled", pops, p0);
    chk("t6_dn_valid", dn_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
